axil_multi_operand_adder: RTL

- Parametrised AXI4-Lite memory-mapped arithmetic slave.
- Holds NUM_OPERANDS software-written operand registers. On START it sums them, or subtracts operands 1..N-1 from operand 0, sequentially at one operand per clock into a widened accumulator.
- Exposes result, extension word, overflow and done status over the same slave port.
- Sits on the s1 AXI4-Lite interconnect port as the next-generation arithmetic peripheral.

---
 rtl/axil_multi_operand_adder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_multi_operand_adder.sv
// AXI4-Lite slave holding NUM_OPERANDS operand registers that are summed (or subtracted from
// operand 0) one operand per clock into a widened accumulator.
module axil_multi_operand_adder #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned NUM_OPERANDS = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  output logic                    done_o
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = ADDR_WIDTH - AddrLsb;
  localparam int unsigned CntW    = $clog2(NUM_OPERANDS);
  localparam int unsigned ExtW    = CntW + 1;
  localparam int unsigned AccW    = DATA_WIDTH + ExtW;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (NUM_OPERANDS < 2 || NUM_OPERANDS > 16) begin : g_bad_operands
    $error("NUM_OPERANDS must be in 2..16");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       k_q, k_d;
  logic [AccW-1:0]       acc_q, acc_d, acc_next;
  logic                  init_q;
  logic                  aw_held_q, w_held_q;
  logic [IdxW-1:0]       aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [StrbW-1:0]      w_strb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mode_q, done_q, ovf_q;
  logic [DATA_WIDTH-1:0] result_lo_q, result_hi_q;
  logic [DATA_WIDTH-1:0] operand_q [NUM_OPERANDS];

  logic                  busy, wr_fire, wr_err, start, finish, done_clr, op_we, ctrl_we;
  int                    wr_word, rd_word;
  logic [DATA_WIDTH-1:0] rd_data, cur_op;
  logic                  rd_err;
  logic [AccW-1:0]       ext_op;
  logic [ExtW-1:0]       acc_upper;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^{s1_axi_awaddr[AddrLsb-1:0], s1_axi_araddr[AddrLsb-1:0]};

  assign busy    = (state_q == StRun);
  assign wr_fire = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_word = int'(aw_idx_q);
  assign rd_word = int'(s1_axi_araddr[ADDR_WIDTH-1:AddrLsb]);

  // Readies stay low through reset and rise on the first clock afterwards.
  assign s1_axi_awready = init_q & ~aw_held_q & ~bvalid_q;
  assign s1_axi_wready  = init_q & ~w_held_q & ~bvalid_q;
  assign s1_axi_arready = init_q & ~rvalid_q;
  assign s1_axi_bvalid  = bvalid_q;
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_rvalid  = rvalid_q;
  assign s1_axi_rresp   = rresp_q;
  assign s1_axi_rdata   = rdata_q;
  assign done_o         = done_q;

  // Write decode
  always_comb begin
    logic is_ctrl, is_status, is_res, is_op;
    is_ctrl   = (wr_word == 0);
    is_status = (wr_word == 1);
    is_res    = (wr_word == 2) || (wr_word == 3);
    is_op     = (wr_word >= 4) && (wr_word < 4 + int'(NUM_OPERANDS));
    wr_err    = 1'b0;
    if (!(is_ctrl || is_status || is_res || is_op)) begin
      wr_err = 1'b1;
    end else if (busy && (is_ctrl || is_op)) begin
      wr_err = 1'b1;
    end
    ctrl_we  = wr_fire & is_ctrl & ~busy & w_strb_q[0];
    start    = ctrl_we & w_data_q[0];
    done_clr = wr_fire & is_status & w_strb_q[0] & w_data_q[1];
    op_we    = wr_fire & is_op & ~busy;
  end

  // Read decode
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_word == 0) begin
      rd_data[1] = mode_q;
    end else if (rd_word == 1) begin
      rd_data[2:0] = {ovf_q, done_q, busy};
    end else if (rd_word == 2) begin
      rd_data = result_lo_q;
    end else if (rd_word == 3) begin
      rd_data = result_hi_q;
    end else if ((rd_word >= 4) && (rd_word < 4 + int'(NUM_OPERANDS))) begin
      for (int i = 0; i < int'(NUM_OPERANDS); i++) begin
        if (rd_word == 4 + i) rd_data = operand_q[i];
      end
    end else begin
      rd_err = 1'b1;
    end
  end

  // Operand fetch and accumulate step
  always_comb begin
    cur_op = '0;
    for (int i = 0; i < int'(NUM_OPERANDS); i++) begin
      if (k_q == CntW'(i)) cur_op = operand_q[i];
    end
    ext_op = mode_q ? {{ExtW{cur_op[DATA_WIDTH-1]}}, cur_op} : {{ExtW{1'b0}}, cur_op};
    if (k_q == '0) begin
      acc_next = ext_op;
    end else if (mode_q) begin
      acc_next = acc_q - ext_op;
    end else begin
      acc_next = acc_q + ext_op;
    end
    acc_upper = acc_next[AccW-1:DATA_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          k_d     = '0;
        end
      end
      StRun: begin
        acc_d = acc_next;
        k_d   = k_q + 1'b1;
        if (k_q == CntW'(NUM_OPERANDS - 1)) begin
          state_d = StIdle;
          k_d     = '0;
          finish  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s1_axi_aclk or posedge s1_axi_areset) begin
    if (s1_axi_areset) begin
      state_q <= StIdle;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge s1_axi_aclk or posedge s1_axi_areset) begin
    if (s1_axi_areset) begin
      init_q      <= 1'b0;
      aw_held_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_held_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      for (int i = 0; i < int'(NUM_OPERANDS); i++) operand_q[i] <= '0;
    end else begin
      init_q <= 1'b1;
      if (s1_axi_awvalid && s1_axi_awready) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s1_axi_awaddr[ADDR_WIDTH-1:AddrLsb];
      end
      if (s1_axi_wvalid && s1_axi_wready) begin
        w_held_q <= 1'b1;
        w_data_q <= s1_axi_wdata;
        w_strb_q <= s1_axi_wstrb;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (bvalid_q && s1_axi_bready) begin
        bvalid_q  <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end

      if (s1_axi_arvalid && s1_axi_arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_err ? 2'b10 : 2'b00;
      end else if (rvalid_q && s1_axi_rready) begin
        rvalid_q <= 1'b0;
      end

      if (ctrl_we) mode_q <= w_data_q[1];
      // Completion wins over a same-cycle DONE clear.
      if (start) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (finish) begin
        done_q      <= 1'b1;
        ovf_q       <= mode_q ? acc_next[AccW-1] : |acc_upper;
        result_lo_q <= acc_next[DATA_WIDTH-1:0];
        result_hi_q <= {{(DATA_WIDTH-ExtW){acc_upper[ExtW-1]}}, acc_upper};
      end else if (done_clr) begin
        done_q <= 1'b0;
      end

      if (op_we) begin
        for (int i = 0; i < int'(NUM_OPERANDS); i++) begin
          if (wr_word == 4 + i) begin
            for (int b = 0; b < int'(StrbW); b++) begin
              if (w_strb_q[b]) operand_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule
